// File: rtl/brg_cgra_dummy_mem_endpoint.sv
// Scratchpad-backed stand-in for the CGRA on one manycore link: serves loads/stores, returns packets.
// Define BRG_CGRA_DUMMY_AMO_EN to build amoswap/amoadd support (AMO_WB state and adder).
module brg_cgra_dummy_mem_endpoint #(
  parameter int addr_width_p   = 28,
  parameter int data_width_p   = 32,
  parameter int x_cord_width_p = 7,
  parameter int y_cord_width_p = 7,
  parameter int mem_els_p      = 1024,
  localparam int link_sif_width_lp = addr_width_p + 24 + 2*data_width_p
                                   + 4*x_cord_width_p + 4*y_cord_width_p
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic [link_sif_width_lp-1:0] link_sif_i,
  output logic [link_sif_width_lp-1:0] link_sif_o,
  input  logic [x_cord_width_p-1:0]    my_x_i,
  input  logic [y_cord_width_p-1:0]    my_y_i,
  output logic [31:0]                  req_count_o,
  output logic [15:0]                  err_count_o
);

  localparam int          idx_w_lp     = $clog2(mem_els_p);
  localparam int unsigned byte_els_lp  = data_width_p / 8;

  typedef struct packed {
    logic [addr_width_p-1:0]   addr;
    logic [3:0]                op;
    logic [byte_els_lp-1:0]    mask;
    logic [4:0]                reg_id;
    logic [data_width_p-1:0]   data;
    logic [y_cord_width_p-1:0] src_y;
    logic [x_cord_width_p-1:0] src_x;
    logic [y_cord_width_p-1:0] y_cord;
    logic [x_cord_width_p-1:0] x_cord;
  } fwd_pkt_s;

  typedef struct packed {
    logic [1:0]                pkt_type;
    logic [data_width_p-1:0]   data;
    logic [4:0]                reg_id;
    logic [y_cord_width_p-1:0] src_y;
    logic [x_cord_width_p-1:0] src_x;
    logic [y_cord_width_p-1:0] y_cord;
    logic [x_cord_width_p-1:0] x_cord;
  } rev_pkt_s;

  typedef struct packed {
    logic     v;
    fwd_pkt_s data;
    logic     ready_and_rev;
  } fwd_link_s;

  typedef struct packed {
    logic     v;
    rev_pkt_s data;
    logic     ready_and_rev;
  } rev_link_s;

  typedef struct packed {
    fwd_link_s fwd;
    rev_link_s rev;
  } link_sif_s;

  typedef enum logic [3:0] {
    e_op_load    = 4'd0,
    e_op_store   = 4'd1,
    e_op_amoswap = 4'd2,
    e_op_amoadd  = 4'd3
  } op_e;

  typedef enum logic [1:0] {
    e_return_credit = 2'd0,
    e_return_int    = 2'd1
  } ret_e;

`ifdef BRG_CGRA_DUMMY_AMO_EN
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_AMO_WB, S_RESP} state_e;
`else
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_e;
`endif

  link_sif_s w_in, w_out;
  assign w_in       = link_sif_i;
  assign link_sif_o = w_out;

  state_e                    r_state, w_state_n;
  logic [3:0]                r_op;
  logic [addr_width_p-1:0]   r_addr;
  logic [data_width_p-1:0]   r_data;
  logic [byte_els_lp-1:0]    r_mask;
  logic [4:0]                r_reg_id;
  logic [x_cord_width_p-1:0] r_src_x;
  logic [y_cord_width_p-1:0] r_src_y;
  ret_e                      r_resp_type;
  logic [data_width_p-1:0]   r_resp_data;
  logic [31:0]               r_req_count;
  logic [15:0]               r_err_count;
  logic [data_width_p-1:0]   r_mem [mem_els_p];

  logic                    w_fwd_ready, w_rev_v, w_accept, w_exec_err;
  logic                    w_in_range, w_is_load, w_is_store, w_is_amo, w_supported;
  logic [idx_w_lp-1:0]     w_idx;
  logic                    w_mem_we;
  logic [byte_els_lp-1:0]  w_mem_wmask;
  logic [data_width_p-1:0] w_mem_wdata;
  logic [1:0]              w_err_inc;
  logic [16:0]             w_err_sum;
  logic                    w_unused;

  assign w_idx      = r_addr[idx_w_lp-1:0];
  assign w_in_range = (r_addr >> idx_w_lp) == '0;
  assign w_is_load  = (r_op == e_op_load);
  assign w_is_store = (r_op == e_op_store);
`ifdef BRG_CGRA_DUMMY_AMO_EN
  assign w_is_amo   = (r_op == e_op_amoswap) || (r_op == e_op_amoadd);
`else
  assign w_is_amo   = 1'b0;
`endif
  assign w_supported = w_is_load || w_is_store || w_is_amo;
  assign w_accept    = w_fwd_ready && w_in.fwd.v;

  always_ff @(posedge clk_i) begin
    if (reset_i) r_state <= S_IDLE;
    else         r_state <= w_state_n;
  end

  always_comb begin
    w_state_n   = r_state;
    w_fwd_ready = 1'b0;
    w_rev_v     = 1'b0;
    w_exec_err  = 1'b0;
    w_mem_we    = 1'b0;
    w_mem_wmask = '0;
    w_mem_wdata = r_data;
    case (r_state)
      S_IDLE: begin
        w_fwd_ready = 1'b1;
        if (w_in.fwd.v) w_state_n = S_EXEC;
      end
      S_EXEC: begin
        w_exec_err = !w_supported || !w_in_range;
        if (w_is_store && w_in_range) begin
          w_mem_we    = 1'b1;
          w_mem_wmask = r_mask;
        end
`ifdef BRG_CGRA_DUMMY_AMO_EN
        w_state_n = (w_is_amo && w_in_range) ? S_AMO_WB : S_RESP;
`else
        w_state_n = S_RESP;
`endif
      end
`ifdef BRG_CGRA_DUMMY_AMO_EN
      S_AMO_WB: begin
        // r_resp_data holds the old word captured in EXEC
        w_mem_we    = 1'b1;
        w_mem_wmask = '1;
        w_mem_wdata = (r_op == e_op_amoswap) ? r_data : r_resp_data + r_data;
        w_state_n   = S_RESP;
      end
`endif
      S_RESP: begin
        w_rev_v = 1'b1;
        if (w_in.rev.ready_and_rev) w_state_n = S_IDLE;
      end
      default: w_state_n = S_IDLE;
    endcase
    if (reset_i) begin
      w_fwd_ready = 1'b0;
      w_rev_v     = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_accept) begin
      r_op     <= w_in.fwd.data.op;
      r_addr   <= w_in.fwd.data.addr;
      r_data   <= w_in.fwd.data.data;
      r_mask   <= w_in.fwd.data.mask;
      r_reg_id <= w_in.fwd.data.reg_id;
      r_src_x  <= w_in.fwd.data.src_x;
      r_src_y  <= w_in.fwd.data.src_y;
    end
  end

  always_ff @(posedge clk_i) begin
    if (r_state == S_EXEC) begin
      if (!w_supported || w_is_store) begin
        r_resp_type <= e_return_credit;
        r_resp_data <= '0;
      end else if (!w_in_range) begin
        r_resp_type <= e_return_int;
        r_resp_data <= 32'hDEADBEEF;
      end else begin
        r_resp_type <= e_return_int;
        r_resp_data <= r_mem[w_idx];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_mem_we) begin
      for (int unsigned b = 0; b < byte_els_lp; b++) begin
        if (w_mem_wmask[b]) r_mem[w_idx][8*b +: 8] <= w_mem_wdata[8*b +: 8];
      end
    end
  end

  // an unexpected rev packet and an EXEC error in the same cycle both count
  assign w_err_inc = {1'b0, w_in.rev.v} + {1'b0, w_exec_err};
  assign w_err_sum = {1'b0, r_err_count} + {15'b0, w_err_inc};

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_req_count <= '0;
      r_err_count <= '0;
    end else begin
      if (w_accept) r_req_count <= r_req_count + 32'd1;
      r_err_count <= w_err_sum[16] ? '1 : w_err_sum[15:0];
    end
  end

  assign req_count_o = r_req_count;
  assign err_count_o = r_err_count;

  always_comb begin
    w_out                     = '0;
    w_out.fwd.v               = 1'b0;
    w_out.fwd.ready_and_rev   = w_fwd_ready;
    w_out.rev.v               = w_rev_v;
    w_out.rev.data.pkt_type   = r_resp_type;
    w_out.rev.data.data       = r_resp_data;
    w_out.rev.data.reg_id     = r_reg_id;
    w_out.rev.data.src_y      = my_y_i;
    w_out.rev.data.src_x      = my_x_i;
    w_out.rev.data.y_cord     = r_src_y;
    w_out.rev.data.x_cord     = r_src_x;
    w_out.rev.ready_and_rev   = 1'b1;
  end

  assign w_unused = ^{w_in.fwd.ready_and_rev, w_in.fwd.data.x_cord,
                      w_in.fwd.data.y_cord, w_in.rev.data};

endmodule

// File: tb/tb_brg_cgra_dummy_mem_endpoint.sv
// Bench for brg_cgra_dummy_mem_endpoint: directed table, multi-cycle corner sequences, randomized model check.
module tb_brg_cgra_dummy_mem_endpoint;

  localparam int AW = 28;
  localparam int DW = 32;
  localparam int XW = 7;
  localparam int YW = 7;
  localparam int MEM_ELS = 1024;
  localparam int LW = AW + 24 + 2*DW + 4*XW + 4*YW;
`ifdef BRG_CGRA_DUMMY_AMO_EN
  localparam bit AMO_EN = 1'b1;
`else
  localparam bit AMO_EN = 1'b0;
`endif

  typedef struct packed {
    logic [AW-1:0] addr; logic [3:0] op; logic [3:0] mask; logic [4:0] reg_id;
    logic [DW-1:0] data; logic [YW-1:0] src_y; logic [XW-1:0] src_x;
    logic [YW-1:0] y_cord; logic [XW-1:0] x_cord;
  } fwd_pkt_s;
  typedef struct packed {
    logic [1:0] pkt_type; logic [DW-1:0] data; logic [4:0] reg_id;
    logic [YW-1:0] src_y; logic [XW-1:0] src_x; logic [YW-1:0] y_cord; logic [XW-1:0] x_cord;
  } rev_pkt_s;
  typedef struct packed { logic v; fwd_pkt_s data; logic ready_and_rev; } fwd_link_s;
  typedef struct packed { logic v; rev_pkt_s data; logic ready_and_rev; } rev_link_s;
  typedef struct packed { fwd_link_s fwd; rev_link_s rev; } link_sif_s;

  typedef struct {
    logic [3:0] op; logic [AW-1:0] addr; logic [31:0] data; logic [3:0] mask;
    logic [1:0] exp_type; logic [31:0] exp_data; int exp_lat; int exp_req; int exp_err;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  link_sif_s     tb_in, tb_out;
  logic [LW-1:0] w_link_o;
  logic [XW-1:0] my_x;
  logic [YW-1:0] my_y;
  logic [31:0]   req_count;
  logic [15:0]   err_count;
  assign tb_out = w_link_o;

  brg_cgra_dummy_mem_endpoint #(
    .addr_width_p(AW), .data_width_p(DW), .x_cord_width_p(XW),
    .y_cord_width_p(YW), .mem_els_p(MEM_ELS)
  ) dut (
    .clk_i(clk), .reset_i(reset), .link_sif_i(tb_in), .link_sif_o(w_link_o),
    .my_x_i(my_x), .my_y_i(my_y), .req_count_o(req_count), .err_count_o(err_count)
  );

  int n_checks = 0;
  int n_fail   = 0;
  vec_t vecs[$];

  logic [31:0] m_mem [MEM_ELS];
  int m_req, m_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void add_vec(input logic [3:0] op, input logic [AW-1:0] addr,
      input logic [31:0] data, input logic [3:0] mask, input logic [1:0] et,
      input logic [31:0] ed, input int el, input int ereq, input int eerr);
    vec_t v;
    v.op = op; v.addr = addr; v.data = data; v.mask = mask; v.exp_type = et;
    v.exp_data = ed; v.exp_lat = el; v.exp_req = ereq; v.exp_err = eerr;
    vecs.push_back(v);
  endfunction

  // Reference: word array with byte merges; counters as plain integers.
  function automatic void model_txn(input logic [3:0] op, input logic [AW-1:0] addr,
      input logic [31:0] wdata, input logic [3:0] mask,
      output logic [1:0] typ, output logic [31:0] rdata, output int lat);
    bit in_range;
    int idx;
    logic [31:0] old;
    in_range = (addr < AW'(MEM_ELS));
    idx = int'(addr) % MEM_ELS;
    m_req++; typ = 2'd0; rdata = '0; lat = 2;
    if (op == 4'd0) begin
      typ = 2'd1;
      if (in_range) rdata = m_mem[idx];
      else begin rdata = 32'hDEADBEEF; m_err++; end
    end else if (op == 4'd1) begin
      if (in_range) begin
        for (int b = 0; b < 4; b++) if (mask[b]) m_mem[idx][8*b +: 8] = wdata[8*b +: 8];
      end else m_err++;
    end else if ((op == 4'd2 || op == 4'd3) && AMO_EN) begin
      typ = 2'd1;
      if (in_range) begin
        old = m_mem[idx];
        rdata = old;
        m_mem[idx] = (op == 4'd2) ? wdata : old + wdata;
        lat = 3;
      end else begin rdata = 32'hDEADBEEF; m_err++; end
    end else m_err++;
  endfunction

  task automatic run_txn(input fwd_pkt_s pkt, input bit rand_bp,
      output rev_pkt_s got, output int lat, output bit tmo);
    int n;
    bit rdy;
    tmo = 1'b0;
    tb_in.fwd.data = pkt;
    tb_in.fwd.v = 1'b1;
    n = 0;
    while (!tb_out.fwd.ready_and_rev) begin
      @(negedge clk); n++;
      if (n > 20) begin tmo = 1'b1; break; end
    end
    @(negedge clk);
    tb_in.fwd.v = 1'b0;
    lat = 1;
    while (!tb_out.rev.v && !tmo) begin
      @(negedge clk); lat++;
      if (lat > 20) tmo = 1'b1;
    end
    got = tb_out.rev.data;
    if (!tmo) begin
      n = 0;
      do begin
        rdy = rand_bp ? ($urandom_range(0, 3) != 0) : 1'b1;
        tb_in.rev.ready_and_rev = rdy;
        @(negedge clk); n++;
      end while (!rdy && n < 20);
      tb_in.rev.ready_and_rev = 1'b1;
    end
  endtask

  task automatic check_resp(input string tag, input fwd_pkt_s pkt, input rev_pkt_s got,
      input int lat, input bit tmo, input logic [1:0] et, input logic [31:0] ed,
      input int el, input int ereq, input int eerr);
    chk({tag, "_timeout"}, 32'(tmo), 32'd0);
    chk({tag, "_type"},    32'(got.pkt_type), 32'(et));
    chk({tag, "_data"},    got.data, ed);
    chk({tag, "_reg_id"},  32'(got.reg_id), 32'(pkt.reg_id));
    chk({tag, "_dest_x"},  32'(got.x_cord), 32'(pkt.src_x));
    chk({tag, "_dest_y"},  32'(got.y_cord), 32'(pkt.src_y));
    chk({tag, "_src_x"},   32'(got.src_x), 32'(my_x));
    chk({tag, "_src_y"},   32'(got.src_y), 32'(my_y));
    chk({tag, "_latency"}, 32'(lat), 32'(el));
    chk({tag, "_req_cnt"}, req_count, 32'(ereq));
    chk({tag, "_err_cnt"}, 32'(err_count), 32'(eerr));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    fwd_pkt_s pkt, pkt2;
    rev_pkt_s got, held;
    int lat, e_req, e_err, el;
    bit tmo, seen_v;
    logic [1:0] et;
    logic [31:0] ed;
    int k;

    tb_in = '0;
    tb_in.rev.ready_and_rev = 1'b1;
    my_x = 7'd3;
    my_y = 7'd5;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_fwd_ready", 32'(tb_out.fwd.ready_and_rev), 32'd0);
    chk("rst_rev_v", 32'(tb_out.rev.v), 32'd0);
    reset = 1'b0;
    #1;
    chk("post_rst_fwd_ready", 32'(tb_out.fwd.ready_and_rev), 32'd1);
    chk("post_rst_rev_v", 32'(tb_out.rev.v), 32'd0);
    chk("post_rst_fwd_v", 32'(tb_out.fwd.v), 32'd0);
    chk("post_rst_rev_ready", 32'(tb_out.rev.ready_and_rev), 32'd1);
    chk("post_rst_req", req_count, 32'd0);
    chk("post_rst_err", 32'(err_count), 32'd0);
    @(negedge clk);

    // op, addr, data, mask, type, data, lat, req, err
    add_vec(4'd1, 28'h10,  32'h12345678, 4'b1111, 2'd0, 32'h0,        2, 1, 0);
    add_vec(4'd0, 28'h10,  32'h0,        4'b0000, 2'd1, 32'h12345678, 2, 2, 0);
    add_vec(4'd1, 28'h10,  32'hAABBCCDD, 4'b0101, 2'd0, 32'h0,        2, 3, 0);
    add_vec(4'd0, 28'h10,  32'h0,        4'b0000, 2'd1, 32'h12BB56DD, 2, 4, 0);
    add_vec(4'd1, 28'h0,   32'h0BADF00D, 4'b1111, 2'd0, 32'h0,        2, 5, 0);
    add_vec(4'd0, 28'h400, 32'h0,        4'b0000, 2'd1, 32'hDEADBEEF, 2, 6, 1);
    add_vec(4'd1, 28'h400, 32'hFFFFFFFF, 4'b1111, 2'd0, 32'h0,        2, 7, 2);
    add_vec(4'd0, 28'h0,   32'h0,        4'b0000, 2'd1, 32'h0BADF00D, 2, 8, 2);
    add_vec(4'hF, 28'h10,  32'h11111111, 4'b1111, 2'd0, 32'h0,        2, 9, 3);
    add_vec(4'd1, 28'h20,  32'h7,        4'b1111, 2'd0, 32'h0,        2, 10, 3);
`ifdef BRG_CGRA_DUMMY_AMO_EN
    add_vec(4'd3, 28'h20,  32'h5,        4'b1111, 2'd1, 32'h7,        3, 11, 3);
    add_vec(4'd0, 28'h20,  32'h0,        4'b0000, 2'd1, 32'hC,        2, 12, 3);
    add_vec(4'd2, 28'h20,  32'h55,       4'b1111, 2'd1, 32'hC,        3, 13, 3);
    add_vec(4'd0, 28'h20,  32'h0,        4'b0000, 2'd1, 32'h55,       2, 14, 3);
    add_vec(4'd0, 28'h8000000, 32'h0,    4'b0000, 2'd1, 32'hDEADBEEF, 2, 15, 4);
`else
    add_vec(4'd3, 28'h20,  32'h5,        4'b1111, 2'd0, 32'h0,        2, 11, 4);
    add_vec(4'd0, 28'h20,  32'h0,        4'b0000, 2'd1, 32'h7,        2, 12, 4);
    add_vec(4'd2, 28'h20,  32'h55,       4'b1111, 2'd0, 32'h0,        2, 13, 5);
    add_vec(4'd0, 28'h20,  32'h0,        4'b0000, 2'd1, 32'h7,        2, 14, 5);
    add_vec(4'd0, 28'h8000000, 32'h0,    4'b0000, 2'd1, 32'hDEADBEEF, 2, 15, 6);
`endif

    foreach (vecs[i]) begin
      pkt = '0;
      pkt.addr = vecs[i].addr; pkt.op = vecs[i].op; pkt.mask = vecs[i].mask;
      pkt.data = vecs[i].data; pkt.reg_id = 5'(i + 1);
      pkt.src_x = XW'(i + 2); pkt.src_y = YW'(i + 9);
      pkt.x_cord = my_x; pkt.y_cord = my_y;
      run_txn(pkt, 1'b0, got, lat, tmo);
      check_resp($sformatf("vec%0d", i), pkt, got, lat, tmo, vecs[i].exp_type,
                 vecs[i].exp_data, vecs[i].exp_lat, vecs[i].exp_req, vecs[i].exp_err);
    end
    e_req = vecs[vecs.size()-1].exp_req;
    e_err = vecs[vecs.size()-1].exp_err;

    // Backpressure: return held 10 cycles with the next request already waiting.
    pkt = '0;  pkt.addr = 28'h10; pkt.op = 4'd0; pkt.reg_id = 5'd9;
    pkt.src_x = 7'd1; pkt.src_y = 7'd2;
    pkt2 = '0; pkt2.addr = 28'h30; pkt2.op = 4'd1; pkt2.mask = 4'hF;
    pkt2.data = 32'hCAFE0001; pkt2.reg_id = 5'd10; pkt2.src_x = 7'd4; pkt2.src_y = 7'd6;
    tb_in.rev.ready_and_rev = 1'b0;
    tb_in.fwd.data = pkt;
    tb_in.fwd.v = 1'b1;
    chk("bp_idle_ready", 32'(tb_out.fwd.ready_and_rev), 32'd1);
    @(negedge clk);
    tb_in.fwd.data = pkt2;
    e_req++;
    chk("bp_first_accept", req_count, 32'(e_req));
    @(negedge clk);
    chk("bp_rev_v", 32'(tb_out.rev.v), 32'd1);
    held = tb_out.rev.data;
    chk("bp_data", held.data, 32'h12BB56DD);
    chk("bp_reg_id", 32'(held.reg_id), 32'd9);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk($sformatf("bp_hold%0d_v", c), 32'(tb_out.rev.v), 32'd1);
      chk($sformatf("bp_hold%0d_stable", c), 32'(tb_out.rev.data == held), 32'd1);
      chk($sformatf("bp_hold%0d_fwd_ready", c), 32'(tb_out.fwd.ready_and_rev), 32'd0);
    end
    chk("bp_hold_req", req_count, 32'(e_req));
    tb_in.rev.ready_and_rev = 1'b1;
    @(negedge clk);
    chk("bp_after_rev_v", 32'(tb_out.rev.v), 32'd0);
    chk("bp_after_fwd_ready", 32'(tb_out.fwd.ready_and_rev), 32'd1);
    chk("bp_after_req", req_count, 32'(e_req));
    @(negedge clk);
    tb_in.fwd.v = 1'b0;
    e_req++;
    chk("bp_next_accept", req_count, 32'(e_req));
    @(negedge clk);
    chk("bp_store_v", 32'(tb_out.rev.v), 32'd1);
    chk("bp_store_type", 32'(tb_out.rev.data.pkt_type), 32'd0);
    chk("bp_store_reg_id", 32'(tb_out.rev.data.reg_id), 32'd10);
    @(negedge clk);
    pkt = '0; pkt.addr = 28'h30; pkt.op = 4'd0; pkt.reg_id = 5'd12; pkt.src_x = 7'd8; pkt.src_y = 7'd9;
    e_req++;
    run_txn(pkt, 1'b0, got, lat, tmo);
    check_resp("bp_load", pkt, got, lat, tmo, 2'd1, 32'hCAFE0001, 2, e_req, e_err);

    // Unexpected rev in IDLE, then coinciding with an out-of-range EXEC.
    tb_in.rev.v = 1'b1;
    @(negedge clk);
    tb_in.rev.v = 1'b0;
    e_err++;
    chk("unexp_rev_err", 32'(err_count), 32'(e_err));
    pkt = '0; pkt.addr = 28'h400; pkt.op = 4'd0; pkt.reg_id = 5'd11; pkt.src_x = 7'd2; pkt.src_y = 7'd3;
    tb_in.fwd.data = pkt;
    tb_in.fwd.v = 1'b1;
    @(negedge clk);
    tb_in.fwd.v = 1'b0;
    tb_in.rev.v = 1'b1;
    e_req++;
    @(negedge clk);
    tb_in.rev.v = 1'b0;
    e_err += 2;
    chk("simul_err_plus2", 32'(err_count), 32'(e_err));
    chk("simul_rev_v", 32'(tb_out.rev.v), 32'd1);
    chk("simul_data", tb_out.rev.data.data, 32'hDEADBEEF);
    @(negedge clk);
    @(negedge clk);
    chk("simul_err_settled", 32'(err_count), 32'(e_err));
    chk("simul_req", req_count, 32'(e_req));

    // Reset during EXEC of a load: the return is dropped.
    pkt = '0; pkt.addr = 28'h10; pkt.op = 4'd0; pkt.reg_id = 5'd13;
    tb_in.fwd.data = pkt;
    tb_in.fwd.v = 1'b1;
    @(negedge clk);
    tb_in.fwd.v = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    seen_v = 1'b0;
    #1;
    chk("midrst_fwd_ready", 32'(tb_out.fwd.ready_and_rev), 32'd1);
    chk("midrst_req", req_count, 32'd0);
    chk("midrst_err", 32'(err_count), 32'd0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (tb_out.rev.v !== 1'b0) seen_v = 1'b1;
    end
    chk("midrst_no_rev_v", 32'(seen_v), 32'd0);

    // Randomized phase against the reference model.
    m_req = 0; m_err = 0;
    for (int i = 0; i < 8; i++) begin
      pkt = '0; pkt.addr = AW'(32'h100 + i); pkt.op = 4'd1; pkt.mask = 4'hF;
      pkt.data = $urandom; pkt.reg_id = 5'($urandom); pkt.src_x = XW'($urandom); pkt.src_y = YW'($urandom);
      model_txn(pkt.op, pkt.addr, pkt.data, pkt.mask, et, ed, el);
      run_txn(pkt, 1'b0, got, lat, tmo);
      check_resp($sformatf("fill%0d", i), pkt, got, lat, tmo, et, ed, el, m_req, m_err);
    end
    for (int i = 0; i < 150; i++) begin
      pkt = '0;
      k = int'($urandom_range(0, 9));
      case (k)
        0, 1, 2, 3: pkt.op = 4'd0;
        4, 5, 6:    pkt.op = 4'd1;
        7:          pkt.op = 4'd2;
        8:          pkt.op = 4'd3;
        default:    pkt.op = 4'($urandom_range(4, 15));
      endcase
      if ($urandom_range(0, 7) == 0)
        pkt.addr = ($urandom_range(0, 1) != 0) ? AW'(MEM_ELS + $urandom_range(0, 1023))
                                               : AW'(32'h0800_0000 | $urandom_range(0, 15));
      else
        pkt.addr = AW'(32'h100 + $urandom_range(0, 7));
      pkt.data = $urandom; pkt.mask = 4'($urandom);
      pkt.reg_id = 5'($urandom); pkt.src_x = XW'($urandom); pkt.src_y = YW'($urandom);
      model_txn(pkt.op, pkt.addr, pkt.data, pkt.mask, et, ed, el);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_txn(pkt, 1'b1, got, lat, tmo);
      check_resp($sformatf("rnd%0d", i), pkt, got, lat, tmo, et, ed, el, m_req, m_err);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
